// File: rtl/prog_loader_pkg.sv
// Shared types for the HPS program loader: FSM states and write-buffer entries.
package prog_loader_pkg;

  localparam int unsigned ENTRY_ADDR_W = 32;
  localparam int unsigned DATA_W       = 8;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]       data;
  } fifo_entry_t;

endpackage

// File: rtl/prog_fifo.sv
// Small synchronous FIFO with occupancy count; push when full and pop when empty are ignored.
module prog_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/prog_loader.sv
// Streams an HPS ioctl download into CPU RAM through a small write buffer,
// optionally taking the load address from a 2-byte little-endian header.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned           ADDR_W     = 16,
  parameter int unsigned           NUM_SLOTS  = 2,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter logic [NUM_SLOTS-1:0]  SLOT_MODE  = 2'b01,
  parameter logic [ADDR_W-1:0]     BIN_BASE   = 16'h8000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_data,
  output logic              ioctl_wait,
  output logic              ram_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  input  logic              ram_ack,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W-1:0] load_start,
  output logic [ADDR_W-1:0] load_end,
  output logic              err_overflow,
  output logic              err_short,
  output logic              err_wrap
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SUM_W = ADDR_W + 2;

  state_t          state;
  logic            dl_q;
  logic            dl_rise;
  logic            dl_fall;
  logic            idx_ok;
  logic            slot_prg;
  logic [7:0]      hdr_lo;
  logic [ADDR_W:0] byte_cnt;
  logic [SUM_W-1:0] wr_sum;
  logic            wr_wrap;
  logic            push;
  fifo_entry_t     push_entry;
  fifo_entry_t     head;
  logic [CNT_W-1:0] fifo_count;
  logic            fifo_full;
  logic            fifo_empty;

  assign dl_rise = ioctl_download & ~dl_q;
  assign dl_fall = ~ioctl_download & dl_q;

  // Next RAM address; any bit above ADDR_W means the load ran past all-ones.
  assign wr_sum  = SUM_W'(load_start) + SUM_W'(byte_cnt);
  assign wr_wrap = |wr_sum[SUM_W-1:ADDR_W];
  assign push    = (state == STREAM) & ioctl_wr & ~fifo_full;

  always_comb begin
    idx_ok   = 1'b0;
    slot_prg = 1'b0;
    for (int k = 0; k < int'(NUM_SLOTS); k++) begin
      if (ioctl_index == 8'(k + 1)) begin
        idx_ok   = 1'b1;
        slot_prg = SLOT_MODE[k];
      end
    end
  end

  always_comb begin
    push_entry      = '0;
    push_entry.addr = ENTRY_ADDR_W'(wr_sum[ADDR_W-1:0]);
    push_entry.data = ioctl_data;
  end

  prog_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (push_entry),
    .pop   (ram_ack),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ram_req    = ~fifo_empty;
  assign ram_addr   = head.addr[ADDR_W-1:0];
  assign ram_din    = head.data;
  assign ioctl_wait = (fifo_count >= CNT_W'(FIFO_DEPTH - 1));

  if (ADDR_W < ENTRY_ADDR_W) begin : g_addr_pad
    logic unused_addr_hi;
    assign unused_addr_hi = ^head.addr[ENTRY_ADDR_W-1:ADDR_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      dl_q         <= 1'b0;
      cpu_hold     <= 1'b0;
      load_done    <= 1'b0;
      load_start   <= '0;
      load_end     <= '0;
      err_overflow <= 1'b0;
      err_short    <= 1'b0;
      err_wrap     <= 1'b0;
      byte_cnt     <= '0;
      hdr_lo       <= '0;
    end else begin
      dl_q      <= ioctl_download;
      load_done <= 1'b0;
      case (state)
        IDLE: begin
          if (dl_rise && idx_ok) begin
            err_overflow <= 1'b0;
            err_short    <= 1'b0;
            err_wrap     <= 1'b0;
            cpu_hold     <= 1'b1;
            byte_cnt     <= '0;
            if (slot_prg) begin
              load_start <= '0;
              state      <= HDR;
            end else begin
              load_start <= BIN_BASE;
              state      <= STREAM;
            end
          end
        end
        HDR: begin
          if (dl_fall) begin
            err_short <= 1'b1;
            state     <= DONE;
          end else if (ioctl_wr) begin
            if (ioctl_addr == 25'd0) begin
              hdr_lo <= ioctl_data;
            end else if (ioctl_addr == 25'd1) begin
              load_start <= ADDR_W'({ioctl_data, hdr_lo});
              state      <= STREAM;
            end
          end
        end
        STREAM: begin
          if (ioctl_wr) begin
            if (fifo_full) begin
              err_overflow <= 1'b1;
            end else begin
              byte_cnt <= byte_cnt + (ADDR_W + 1)'(1);
              if (wr_wrap) err_wrap <= 1'b1;
            end
          end
          if (dl_fall) state <= DRAIN;
        end
        DRAIN: begin
          if (fifo_empty) state <= DONE;
        end
        DONE: begin
          load_done <= 1'b1;
          load_end  <= wr_sum[ADDR_W-1:0];
          cpu_hold  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader against an address/byte scoreboard model.
module tb_prog_loader;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wait;
  logic        ram_req;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_ack;
  logic        cpu_hold;
  logic        load_done;
  logic [15:0] load_start;
  logic [15:0] load_end;
  logic        err_overflow;
  logic        err_short;
  logic        err_wrap;

  prog_loader #(
    .ADDR_W     (16),
    .NUM_SLOTS  (2),
    .FIFO_DEPTH (DEPTH),
    .SLOT_MODE  (2'b01),
    .BIN_BASE   (16'h8000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_data     (ioctl_data),
    .ioctl_wait     (ioctl_wait),
    .ram_req        (ram_req),
    .ram_addr       (ram_addr),
    .ram_din        (ram_din),
    .ram_ack        (ram_ack),
    .cpu_hold       (cpu_hold),
    .load_done      (load_done),
    .load_start     (load_start),
    .load_end       (load_end),
    .err_overflow   (err_overflow),
    .err_short      (err_short),
    .err_wrap       (err_wrap)
  );

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [7:0]  tx [64];
  int          n_vec = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  int          ack_mode = 0;   // 0: always ack, 1: random ack, 2: never ack
  bit          stall_q = 1'b0;
  logic [15:0] hold_a;
  logic [7:0]  hold_d;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ram_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ack_mode)
        0:       ram_ack = 1'b1;
        1:       ram_ack = 1'($urandom_range(0, 1));
        default: ram_ack = 1'b0;
      endcase
    end
  end

  // RAM-side scoreboard, done-pulse counter and stall-stability checks.
  always @(negedge clk) begin
    if (load_done === 1'b1) done_cnt++;
    if (!reset && ram_req && ram_ack) begin
      chk("wr_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(ram_addr), 32'(mon_e.a));
        chk("wr_data", 32'(ram_din), 32'(mon_e.d));
      end
    end
    if (!reset && stall_q && ram_req) begin
      chk("hold_addr", 32'(ram_addr), 32'(hold_a));
      chk("hold_din", 32'(ram_din), 32'(hold_d));
    end
    stall_q = !reset && ram_req && !ram_ack;
    hold_a  = ram_addr;
    hold_d  = ram_din;
  end

  task automatic do_load(input int slot, input bit prg, input int n, input bit honor_wait);
    int hdr_n;
    int start;
    int acc;
    bit wrap;
    bit short_l;
    bit ovf;
    int d0;
    int t;
    hdr_n   = prg ? 2 : 0;
    start   = prg ? int'({tx[1], tx[0]}) : 32'h8000;
    short_l = prg && (n < 2);
    acc     = 0;
    wrap    = 1'b0;
    ovf     = 1'b0;

    ioctl_index    = 8'(slot);
    ioctl_download = 1'b1;
    tick();
    chk("cpu_hold_on", 32'(cpu_hold), 32'd1);
    chk("err_clear", 32'({err_overflow, err_short, err_wrap}), 32'd0);

    for (int i = 0; i < n; i++) begin
      if (honor_wait) begin
        repeat ($urandom_range(0, 2)) tick();
        t = 0;
        while (ioctl_wait && t < 1000) begin
          tick();
          t++;
        end
        if (t >= 1000) chk("wait_timeout", 32'(ioctl_wait), 32'd0);
      end
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_data = tx[i];
      if (i >= hdr_n) begin
        if (honor_wait || acc < DEPTH) begin
          exp_q.push_back('{a: 16'(start + acc), d: tx[i]});
          if (start + acc > 32'hFFFF) wrap = 1'b1;
          acc++;
        end else begin
          ovf = 1'b1;
        end
      end
      tick();
      ioctl_wr = 1'b0;
      if (!honor_wait && i >= hdr_n) chk("ioctl_wait", 32'(ioctl_wait), 32'(acc >= DEPTH - 1));
    end

    if (!honor_wait) ack_mode = 0;
    ioctl_download = 1'b0;
    d0 = done_cnt;
    t  = 0;
    while (done_cnt == d0 && t < 500) begin
      tick();
      t++;
    end
    chk("load_done", 32'(done_cnt - d0), 32'd1);
    repeat (3) tick();
    chk("done_single", 32'(done_cnt - d0), 32'd1);
    chk("cpu_hold_off", 32'(cpu_hold), 32'd0);
    chk("drained", 32'(exp_q.size()), 32'd0);
    chk("err_short", 32'(err_short), 32'(short_l));
    chk("err_wrap", 32'(err_wrap), 32'(wrap));
    chk("err_overflow", 32'(err_overflow), 32'(ovf));
    if (!short_l) begin
      chk("load_start", 32'(load_start), 32'(start & 32'hFFFF));
      chk("load_end", 32'(load_end), 32'((start + acc) & 32'hFFFF));
    end
  endtask

  initial begin
    int d0;
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'd0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_data     = '0;
    repeat (3) tick();
    chk("rst_ram_req", 32'(ram_req), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_ioctl_wait", 32'(ioctl_wait), 32'd0);
    chk("rst_errs", 32'({err_overflow, err_short, err_wrap}), 32'd0);
    chk("rst_load_start", 32'(load_start), 32'd0);
    chk("rst_load_end", 32'(load_end), 32'd0);
    reset = 1'b0;
    tick();

    // PRG header 00 80, then AA BB CC with immediate ack
    ack_mode = 0;
    tx[0] = 8'h00; tx[1] = 8'h80; tx[2] = 8'hAA; tx[3] = 8'hBB; tx[4] = 8'hCC;
    do_load(1, 1'b1, 5, 1'b1);

    // BIN slot, three bytes at the fixed base
    for (int i = 0; i < 3; i++) tx[i] = 8'($urandom);
    do_load(2, 1'b0, 3, 1'b1);

    // Backpressure ignored with no acks: four buffered, two dropped
    ack_mode = 2;
    repeat (2) tick();
    for (int i = 0; i < 6; i++) tx[i] = 8'($urandom);
    do_load(2, 1'b0, 6, 1'b0);

    // Header FF FF wraps on the second payload byte
    ack_mode = 0;
    tx[0] = 8'hFF; tx[1] = 8'hFF; tx[2] = 8'h11; tx[3] = 8'h22;
    do_load(1, 1'b1, 4, 1'b1);

    // Truncated header
    tx[0] = 8'h12;
    do_load(1, 1'b1, 1, 1'b1);

    // Unserved index is ignored
    ioctl_index    = 8'd3;
    ioctl_download = 1'b1;
    repeat (3) tick();
    chk("bad_index_hold", 32'(cpu_hold), 32'd0);
    ioctl_download = 1'b0;
    tick();

    // Reset mid-stream abandons queued bytes
    ack_mode = 2;
    repeat (2) tick();
    ioctl_index    = 8'd2;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_data = 8'($urandom);
      tick();
    end
    ioctl_wr = 1'b0;
    tick();
    chk("queued_req", 32'(ram_req), 32'd1);
    reset          = 1'b1;
    ioctl_download = 1'b0;
    d0 = done_cnt;
    tick();
    chk("rst_mid_req", 32'(ram_req), 32'd0);
    chk("rst_mid_hold", 32'(cpu_hold), 32'd0);
    chk("rst_mid_done", 32'(load_done), 32'd0);
    reset    = 1'b0;
    ack_mode = 0;
    repeat (6) tick();
    chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rst_idle_req", 32'(ram_req), 32'd0);

    // Randomized loads across both slots, ack patterns and near-wrap headers
    for (int r = 0; r < 24; r++) begin
      int  slot;
      int  n;
      bit  prg;
      slot = int'($urandom_range(1, 2));
      prg  = (slot == 1);
      n    = int'($urandom_range(0, 10));
      for (int i = 0; i < 10; i++) tx[i] = 8'($urandom);
      if (prg && $urandom_range(0, 2) == 0) begin
        tx[0] = 8'($urandom_range(8'hF8, 8'hFF));
        tx[1] = 8'hFF;
      end
      ack_mode = int'($urandom_range(0, 1));
      do_load(slot, prg, n, 1'b1);
    end

    ack_mode = 0;
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, giving the RAM address width in bits.
REQ-002 SHALL have parameter NUM_SLOTS, default 2, giving the number of ioctl indices served (1..NUM_SLOTS).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4 (power of 2, >=2), giving the depth of the write buffer.
REQ-004 SHALL have parameter SLOT_MODE, NUM_SLOTS bits, default 2'b01; bit k-1 set means slot k is PRG, clear means BIN.
REQ-005 SHALL have parameter BIN_BASE, default 16'h8000, giving the BIN-mode load base address.
REQ-006 SHALL have the ports: clk  in  1  system clock; all logic clocked on its rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 ioctl_download  in  1  transfer active; ioctl_index  in  8  file slot; ioctl_wr  in  1  byte strobe; ioctl_addr  in  25  byte offset; ioctl_data  in  8  byte.
REQ-009 ioctl_wait  out  1  backpressure to the HPS.
REQ-010 ram_req  out  1; ram_addr  out  ADDR_W; ram_din  out  8; ram_ack  in  1; together these form the write handshake.
REQ-011 cpu_hold  out  1  keeps the CPU halted while a load is in progress.
REQ-012 load_done  out  1  one-cycle pulse at the end of a load.
REQ-013 load_start  out  ADDR_W  load address; load_end  out  ADDR_W  last written address + 1.
REQ-014 err_overflow, err_short, err_wrap  out  1 each  sticky error flags.

Function
REQ-015 SHALL implement FSM states IDLE, HDR, STREAM, DRAIN, DONE.
REQ-016 IDLE->HDR (PRG slot) or IDLE->STREAM (BIN slot) SHALL occur on the rising edge of ioctl_download with ioctl_index in 1..NUM_SLOTS; other indices are ignored and the FSM stays in IDLE.
REQ-017 Entering HDR/STREAM SHALL clear all error flags and assert cpu_hold in the same cycle.
REQ-018 In HDR, the two bytes at ioctl_addr 0 and 1 SHALL form a little-endian load address held in load_start; these bytes are not written to RAM; HDR->STREAM after byte 1.
REQ-019 In BIN mode, load_start SHALL equal BIN_BASE.
REQ-020 Each payload byte SHALL be queued as {addr,data}: addr = load_start + running count, truncated to ADDR_W.
REQ-021 On a carry out of ADDR_W (address wrap past all-ones), err_wrap SHALL set and the write SHALL still proceed at the wrapped address.
REQ-022 ioctl_wait SHALL be high whenever the FIFO count >= FIFO_DEPTH-1.
REQ-023 An ioctl_wr while the FIFO is full SHALL drop the byte, set err_overflow, and not advance the count.
REQ-024 ram_req SHALL be high whenever the FIFO is non-empty; ram_addr/ram_din SHALL show the head entry and stay stable until ram_ack.
REQ-025 ram_ack high with ram_req SHALL pop the head entry at that edge; the next entry may be presented in the following cycle.
REQ-026 A push and a pop in the same cycle SHALL leave the count unchanged.
REQ-027 A falling edge of ioctl_download in STREAM SHALL go to DRAIN; in HDR it SHALL set err_short and go to DONE.
REQ-028 DRAIN->DONE SHALL occur when the FIFO is empty.
REQ-029 DONE SHALL pulse load_done for one cycle, latch load_end, deassert cpu_hold, and return to IDLE.
REQ-030 Load latency SHALL be that a byte accepted at cycle N presents on ram_req no earlier than N+1.
REQ-031 A rising edge of ioctl_download while not in IDLE SHALL be ignored.

Reset
REQ-032 Reset SHALL force IDLE and empty the FIFO, and drive ram_req, cpu_hold, load_done, ioctl_wait and all error flags to 0, with load_start and load_end at 0.
REQ-033 Reset mid-load SHALL abandon queued bytes without issuing load_done.

Structure
REQ-034 The FSM state enum and the FIFO entry struct {addr, data} SHALL live in package prog_loader_pkg.
REQ-035 The buffer SHALL be a sub-module prog_fifo (parametrised width/depth, count output, push/pop, full/empty).

Verification
REQ-036 PRG slot 1, bytes 00 80 AA BB CC with immediate ack -> writes 8000=AA, 8001=BB, 8002=CC; load_end=8003; one load_done pulse.
REQ-037 BIN slot 2, 3 bytes -> writes at 8000..8002; load_start=8000.
REQ-038 ram_ack held low, 6 bytes pushed ignoring ioctl_wait -> ioctl_wait high at count 3; 2 bytes dropped; err_overflow=1.
REQ-039 PRG header FF FF then 2 bytes -> writes FFFF, then 0000; err_wrap=1.
REQ-040 PRG download of 1 byte -> err_short=1, no RAM write, load_done pulse, cpu_hold=0.
REQ-041 Reset asserted in STREAM with 2 queued entries -> next cycle ram_req=0, cpu_hold=0, no load_done.
